spi_slave_if: RTL
=================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front-end that sits directly upstream of the single-port RAM. It deserialises MOSI frames into
//  10-bit RAM commands (rx_data/rx_valid -> RAM din/rx_valid). It also serialises RAM read data
//  (RAM dout/tx_valid -> tx_data/tx_valid) back out on MISO.
//  Single clock domain: SPI bits are sampled and driven on rising clk; SS_n frames each transaction.
// PARAMETERS
//  ADDR_SIZE   8   RAM address/data width; rx_data is ADDR_SIZE+2 bits (2-bit command + payload)
// PORTS
//  clk       in   1              system/SPI clock, rising-edge
//  rst_n     in   1              asynchronous, active-low reset
//  SS_n      in   1              slave select, active-low; high aborts/ends a frame
//  MOSI      in   1              serial data in, MSB first
//  MISO      out  1              serial data out, MSB first; 0 when not shifting
//  rx_data   out  ADDR_SIZE+2    parallel command word to RAM: {cmd[1:0], payload}
//  rx_valid  out  1              one-cycle strobe, rx_data valid
//  tx_data   in   ADDR_SIZE      read data from RAM
//  tx_valid  in   1              RAM read data valid strobe
// BEHAVIOUR
//  Reset: state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. SS_n=1 in any state -> next state IDLE.
//  IDLE: SS_n=0 -> CHK_CMD.
//  CHK_CMD: MOSI is sampled as rx bit 9 (frame bit 1).
//   - MOSI=0 -> WRITE.
//   - MOSI=1 & !rd_addr_seen -> READ_ADD.
//   - MOSI=1 & rd_addr_seen -> READ_DATA.
//  WRITE/READ_ADD/READ_DATA receive: the next 9 MOSI bits are shifted in (bits 8..0), giving 10 bits per frame.
//   - On the edge that samples bit 0: rx_data <= full word, and rx_valid=1 for exactly 1 cycle (registered).
//   - Latency: rx_valid is high in the 11th cycle after CHK_CMD entry (CHK_CMD = cycle 1).
//   - Extra MOSI bits after bit 0 are ignored until SS_n rises. rx_data holds its value until the next frame completes.
//  READ_ADD: rd_addr_seen <= 1 in the same cycle rx_valid is asserted.
//  READ_DATA transmit phase, after rx_valid:
//   - Wait for tx_valid; latch tx_data on the first cycle tx_valid=1.
//   - Drive MISO = latched bits 7..0 (registered), one bit per cycle over the following 8 cycles.
//   - Then MISO=0 and rd_addr_seen <= 0.
//  Command bits are passed through unchecked; the RAM decodes cmd.
//  tx_valid outside READ_DATA wait phase: ignored.
//  Abort (SS_n=1 mid-frame): no rx_valid, counter cleared, MISO=0 next cycle, rd_addr_seen unchanged.
//  Simultaneous SS_n rise with the bit-0 sample: frame discarded, no rx_valid.
//  Bit counter is 4 bits and saturates once the frame is done; no wrap-around into a new frame without SS_n high.
//  Async reset mid-frame: immediate return to reset values, independent of clk.
// STRUCTURE
//  Shared package spi_ram_pkg:
//   - state enum/localparams (IDLE=0..READ_DATA=4).
//   - command codes: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
//   - FRAME_BITS=ADDR_SIZE+2.
//  Sub-module spi_piso_8: load/shift-out register for MISO (load on tx_valid, 8-bit down-counter).
//  All other logic is the FSM, serial-in register and counters in this file.
// TESTING
//  1 Write address: SS_n=0, send 0+00_0010_1000 (CHK bit 0 then 9 bits)
//    -> rx_data=10'h028, rx_valid high 1 cycle, state returns to IDLE after SS_n=1.
//  2 Write data: frame 01_1010_1010
//    -> rx_data=10'h1AA, one rx_valid; rd_addr_seen stays 0.
//  3 Read address frame 10_0010_1000 -> rx_data=10'h228 and rd_addr_seen=1.
//    Then read-data frame 11_xxxx_xxxx -> state READ_DATA, rx_valid pulse.
//    Model returns tx_data=8'hA5 with tx_valid -> MISO 1,0,1,0,0,1,0,1 over 8 cycles, then 0.
//    rd_addr_seen=0 afterwards.
//  4 Abort: SS_n=1 after 5 bits of a write frame -> no rx_valid, IDLE next cycle.
//    The next full frame decodes correctly.
//  5 Read data without prior read address: bit1=1 with rd_addr_seen=0 -> READ_ADD, not READ_DATA.
//    Also: spurious tx_valid in WRITE leaves MISO=0.
//  6 Reset: assert rst_n=0 mid READ_DATA shift -> MISO, rx_valid, rx_data, rd_addr_seen all 0 immediately.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared states, command codes and frame geometry for the SPI-to-RAM path
package spi_ram_pkg;
  localparam int ADDR_W = 8;
  localparam int FRAME_BITS = ADDR_W + 2;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;
endpackage

// File: rtl/spi_piso_8.sv
// spi_piso_8: loads a read byte and shifts it out MSB first on a registered serial output
module spi_piso_8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         dout,
  output logic         last
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  d;
  logic [CW-1:0] n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d    <= '0;
      n    <= '0;
      dout <= 1'b0;
    end else if (clr) begin
      n    <= '0;
      dout <= 1'b0;
    end else if (load) begin
      dout <= din[W-1];
      d    <= {din[W-2:0], 1'b0};
      n    <= CW'(W - 1);
    end else if (n != '0) begin
      dout <= d[W-1];
      d    <= {d[W-2:0], 1'b0};
      n    <= n - 1'b1;
    end else begin
      dout <= 1'b0;
    end
  end
  // high on the edge that retires the final bit
  assign last = (n == CW'(1)) && !clr;
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave deserialising command frames for the RAM and serialising read data back
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  localparam int FW = ADDR_SIZE + 2;
  state_t        state, nxt;
  logic [3:0]    cnt;
  logic [FW-2:0] sr;
  logic          rd_addr_seen, tx_started, rx_st, load, last;
  assign rx_st = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign load  = (state == READ_DATA) && (cnt == 4'(FW)) && !tx_started && tx_valid && !SS_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (SS_n) nxt = IDLE;
    else if (state == IDLE) nxt = CHK_CMD;
    else if (state == CHK_CMD) nxt = !MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
  end
  // counter saturates at FW so trailing MOSI bits cannot start a new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sr           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_started   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        cnt        <= '0;
        tx_started <= 1'b0;
      end else if (state == CHK_CMD) begin
        sr  <= {sr[FW-3:0], MOSI};
        cnt <= 4'd1;
      end else if (rx_st && cnt < 4'(FW)) begin
        sr  <= {sr[FW-3:0], MOSI};
        cnt <= cnt + 4'd1;
        if (cnt == 4'(FW - 1)) begin
          rx_data  <= {sr, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD) rd_addr_seen <= 1'b1;
        end
      end
      if (load) tx_started <= 1'b1;
      if (last) rd_addr_seen <= 1'b0;
    end
  end
  spi_piso_8 #(.W(ADDR_SIZE)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (SS_n),
    .load  (load),
    .din   (tx_data),
    .dout  (MISO),
    .last  (last)
  );
endmodule
